// File: rtl/apb_irq_collector.sv
// Latches interrupt source rising edges into a W1C pending register; raises a masked, lowest-index-first level irq.
// Zero-wait APB slave (PREADY tied 1); irq_o follows a source edge by 1 cycle, or 3 with IRQ_COLLECTOR_SYNC_EN defined.
module apb_irq_collector #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_SRC        = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_SRC-1:0]        irq_src_i,
  output logic                      irq_o,
  output logic [4:0]                irq_id_o,
  input  logic                      irq_ack_i
);

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_SET     = 2'd2;
  localparam logic [1:0] REG_ID      = 2'd3;

  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_src_q;

  logic [NUM_SRC-1:0] w_src;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_ack_oh;
  logic [NUM_SRC-1:0] w_active;
  logic               w_access;
  logic               w_wr;
  logic [1:0]         w_idx;
  logic               w_unused;

`ifdef IRQ_COLLECTOR_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_src_i;
`endif

  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign w_access = PSEL & PENABLE;
  assign w_wr     = w_access & PWRITE;
  assign w_idx    = PADDR[3:2];
  assign w_unused = ^{PADDR, PWDATA};

  // src_q resets to 0, so a source already high at reset release counts as one edge
  assign w_rise   = w_src & ~r_src_q;
  assign w_set    = (w_wr && (w_idx == REG_SET)) ? PWDATA[NUM_SRC-1:0] : '0;
  assign w_active = r_pending & r_mask;
  assign irq_o    = |w_active;

  always_comb begin
    irq_id_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) irq_id_o = 5'(i);
    end
  end

  always_comb begin
    w_ack_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ack_oh[i] = irq_ack_i & irq_o & (irq_id_o == 5'(i));
    end
  end

  assign w_clr = ((w_wr && (w_idx == REG_PENDING)) ? PWDATA[NUM_SRC-1:0] : '0) | w_ack_oh;

  // Set terms are ORed after the clear so a coincident event is never lost
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_src_q   <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise | w_set;
      r_src_q   <= w_src;
      if (w_wr && (w_idx == REG_MASK)) r_mask <= PWDATA[NUM_SRC-1:0];
    end
  end

  always_comb begin
    PRDATA = '0;
    if (w_access && !PWRITE) begin
      case (w_idx)
        REG_PENDING: PRDATA[NUM_SRC-1:0] = r_pending;
        REG_MASK:    PRDATA[NUM_SRC-1:0] = r_mask;
        REG_ID:      PRDATA = {irq_o, 26'b0, irq_id_o};
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_irq_collector.sv
// Scoreboarded bench for apb_irq_collector: stimulus pushes model expectations, a monitor checks every APB read.
module tb_apb_irq_collector;

  localparam int AW = 12;
  localparam int NS = 8;
`ifdef IRQ_COLLECTOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [NS-1:0] irq_src_i;
  logic          irq_o;
  logic [4:0]    irq_id_o;
  logic          irq_ack_i;

  apb_irq_collector #(.APB_ADDR_WIDTH(AW), .NUM_SRC(NS)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_src_i(irq_src_i),
    .irq_o(irq_o), .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        irq;
    logic [4:0]  id;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  string         rn[4] = '{"pending", "mask", "set", "id"};
  logic [NS-1:0] src_v;

  // Reference model: one bit per source, events applied by the register rules
  bit            m_pend[NS];
  bit            m_mask[NS];
  bit            m_prev[NS];
  logic [NS-1:0] m_hist[$];

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = 0;
      m_mask[i] = 0;
      m_prev[i] = 0;
    end
    m_hist.delete();
    for (int i = 0; i < LAT; i++) m_hist.push_back('0);
  endfunction

  function automatic bit m_irq();
    for (int i = 0; i < NS; i++) if (m_pend[i] && m_mask[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_id();
    for (int i = 0; i < NS; i++) if (m_pend[i] && m_mask[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    logic [31:0] d;
    d = '0;
    case (idx)
      0: for (int i = 0; i < NS; i++) d[i] = m_pend[i];
      1: for (int i = 0; i < NS; i++) d[i] = m_mask[i];
      3: begin
        d[31]  = m_irq();
        d[4:0] = 5'(m_id());
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic void m_step(input bit sel, input bit en, input bit wr, input int idx,
                                 input logic [31:0] wd, input logic [NS-1:0] src, input bit ack);
    logic [NS-1:0] eff;
    bit irq_now, set_b, clr_b, wacc;
    int id_now;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    irq_now = m_irq();
    id_now  = m_id();
    wacc    = sel && en && wr;
    m_hist.push_back(src);
    eff = m_hist.pop_front();
    for (int i = 0; i < NS; i++) begin
      set_b = (eff[i] && !m_prev[i]) || (wacc && idx == 2 && wd[i]);
      clr_b = (wacc && idx == 0 && wd[i]) || (ack && irq_now && id_now == i);
      if (set_b) m_pend[i] = 1;
      else if (clr_b) m_pend[i] = 0;
      m_prev[i] = eff[i];
      if (wacc && idx == 1) m_mask[i] = wd[i];
    end
  endfunction

  task automatic tick(input bit sel, input bit en, input bit wr, input int idx,
                      input logic [31:0] wd, input bit ack);
    exp_t e;
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[3:2] = 2'(idx);
    a[1:0] = 2'b00;
    PADDR = a; PSEL = sel; PENABLE = en; PWRITE = wr; PWDATA = wd;
    irq_src_i = src_v; irq_ack_i = ack;
    if (sel && en && !wr) begin
      e.idx = idx; e.data = m_read(idx); e.irq = m_irq(); e.id = 5'(m_id());
      exp_q.push_back(e);
    end
    @(posedge HCLK);
    m_step(sel, en, wr, idx, wd, src_v, ack);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    tick(1, 0, 1, idx, d, 0);
    tick(1, 1, 1, idx, d, 0);
  endtask

  task automatic rd(input int idx);
    tick(1, 0, 0, idx, 32'h0, 0);
    tick(1, 1, 0, idx, 32'h0, 0);
  endtask

  task automatic do_ack();
    tick(0, 0, 0, 0, 32'h0, 1);
  endtask

  task automatic release_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    m_step(0, 0, 0, 0, 32'h0, src_v, 0);
    #1;
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // Monitor: every completed APB read pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && PSEL && PENABLE && !PWRITE) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_read: PRDATA=%h with no expectation queued", PRDATA);
        end else begin
          e = exp_q.pop_front();
          if (PRDATA !== e.data || irq_o !== e.irq || irq_id_o !== e.id ||
              PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL read_%s: got PRDATA=%h irq_o=%b irq_id_o=%0d ready=%b err=%b, expected PRDATA=%h irq_o=%b irq_id_o=%0d ready=1 err=0",
                     rn[e.idx], PRDATA, irq_o, irq_id_o, PREADY, PSLVERR, e.data, e.irq, e.id);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded 500000 ns");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    irq_ack_i = 0; src_v = '0; irq_src_i = '0;
    model_reset();
    repeat (3) @(posedge HCLK);
    release_reset();

    // Reset state
    rd(0); rd(1); rd(3); rd(2);

    // Single pulse, then W1C
    wr(1, 32'hFF);
    src_v[3] = 1'b1; idle(1); src_v = '0; idle(LAT);
    rd(0); rd(3);
    wr(0, 32'h08); rd(3);

    // Two simultaneous sources, served lowest first by ack
    src_v = 8'h22; idle(1); src_v = '0; idle(LAT);
    rd(3); do_ack(); rd(0); rd(3); do_ack(); rd(3);

    // Masked source still latches; unmasking raises irq
    wr(1, 32'h00);
    src_v[2] = 1'b1; idle(1); src_v = '0; idle(LAT);
    rd(0); rd(3); wr(1, 32'h04); rd(3);
    wr(0, 32'h04); rd(0);

    // W1C and a new edge on the same bit in the same cycle
    src_v[0] = 1'b1; idle(1); src_v = '0; idle(LAT + 1);
    rd(0);
    if (LAT == 0) begin
      tick(1, 0, 1, 0, 32'h01, 0);
      src_v[0] = 1'b1;
      tick(1, 1, 1, 0, 32'h01, 0);
    end else begin
      src_v[0] = 1'b1;
      idle(LAT - 1);
      tick(1, 0, 1, 0, 32'h01, 0);
      tick(1, 1, 1, 0, 32'h01, 0);
    end
    src_v = '0; idle(LAT);
    rd(0);

    // Held level sets pending only once; SET register; async reset
    wr(0, 32'hFF); wr(1, 32'hFF);
    src_v[4] = 1'b1; idle(LAT + 2);
    rd(3); do_ack(); idle(2); rd(0);
    src_v = '0;
    wr(2, 32'h80); rd(0); rd(3);
    #2;
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (irq_o !== 1'b0 || irq_id_o !== 5'd0 || PRDATA !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got irq_o=%b irq_id_o=%0d PRDATA=%h, expected 0 0 0", irq_o, irq_id_o, PRDATA);
    end
    model_reset();
    @(posedge HCLK); #1;
    idle(2);
    release_reset();
    rd(0); rd(1); rd(3);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, NS - 1);
        src_v[k] = ~src_v[k];
      end
      r = $urandom_range(0, 9);
      if (r <= 2) idle(1);
      else if (r <= 4) wr($urandom_range(0, 3), $urandom & $urandom);
      else if (r <= 7) rd($urandom_range(0, 3));
      else do_ack();
    end

    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    summary();
    $finish;
  end

endmodule
